puzzle_gpu_core: RTL and testbench

- Parametrised successor to the sliding-puzzle display/controller core.
- Accepts user move instructions, drives row/column shift writes into the offset RAM, and tracks a cursor. Tracks game state (armed/play/win) and counts moves.
- Produces registered VGA pixel colour for a windowed grid of GRID_SIZE x GRID_SIZE tiles. Supports non-power-of-two grids, a restart command and a configurable flash rate.
- Sits between the input decoder, the pixel mapper, the offset RAM and the VGA timing block.

---
 rtl/puzzle_gpu_core.sv | 195 +++++++++++++++++++
 tb/tb_puzzle_gpu_core.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/puzzle_gpu_core.sv
// Sliding-puzzle controller: move/instruction handling, offset RAM write strobes,
// game state tracking, and registered windowed VGA pixel colour with cursor/win flash.
module puzzle_gpu_core #(
    parameter int GRID_BITS  = 4,
    parameter int GRID_SIZE  = 16,
    parameter int FLASH_BITS = 25,
    parameter int MOVE_BITS  = 16,
    parameter int WIN_X_MIN  = 231,
    parameter int WIN_X_MAX  = 711,
    parameter int WIN_Y_MIN  = 36,
    parameter int WIN_Y_MAX  = 516
) (
    input  logic                   sysclk,
    input  logic                   sysrst_n,
    input  logic [3:0]             instruction,
    input  logic                   scramble,
    input  logic                   offset_all_zero,
    input  logic [21:0]            display_addr,
    input  logic [GRID_BITS-1:0]   mapper_pixel_x,
    input  logic [GRID_BITS-1:0]   mapper_pixel_y,
    input  logic [GRID_BITS-1:0]   offset_x,
    input  logic [GRID_BITS-1:0]   offset_y,
    input  logic [2:0]             pixel_data,
    output logic [21:0]            mapper_display_addr,
    output logic [GRID_BITS-1:0]   offset_pos_x,
    output logic [GRID_BITS-1:0]   offset_pos_y,
    output logic [2*GRID_BITS-1:0] pixel_addr,
    output logic [2:0]             display_data,
    output logic                   ram_write,
    output logic [GRID_BITS-1:0]   ram_write_pos,
    output logic                   ram_write_horizontal,
    output logic                   ram_write_increase,
    output logic                   ram_reset,
    output logic [MOVE_BITS-1:0]   move_count,
    output logic [1:0]             game_state
);

    typedef enum logic [1:0] {
        ST_ARMED = 2'd0,
        ST_PLAY  = 2'd1,
        ST_WIN   = 2'd2
    } state_t;

    localparam logic [GRID_BITS-1:0] LAST  = GRID_BITS'(GRID_SIZE - 1);
    localparam logic [GRID_BITS:0]   MODV  = (GRID_BITS + 1)'(GRID_SIZE);
    localparam logic [10:0]          X_MIN = 11'(WIN_X_MIN);
    localparam logic [10:0]          X_MAX = 11'(WIN_X_MAX);
    localparam logic [10:0]          Y_MIN = 11'(WIN_Y_MIN);
    localparam logic [10:0]          Y_MAX = 11'(WIN_Y_MAX);

    state_t                  state, next_state;
    logic                    busy, busy_next;
    logic [GRID_BITS-1:0]    cursor_x, cursor_y, cursor_x_next, cursor_y_next;
    logic                    wr_issue, rst_issue, count_clear;
    logic [GRID_BITS-1:0]    wr_pos_next;
    logic                    wr_horiz_next, wr_inc_next;
    logic [1:0]              settle;
    logic [FLASH_BITS-1:0]   flash_cnt;
    logic                    phase;
    logic [GRID_BITS-1:0]    px, py;
    logic                    in_window, at_cursor;
    logic [2:0]              pix_next;

    function automatic logic [GRID_BITS-1:0] mod_add(input logic [GRID_BITS-1:0] a,
                                                     input logic [GRID_BITS-1:0] b);
        logic [GRID_BITS:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= MODV) sum = sum - MODV;
        return sum[GRID_BITS-1:0];
    endfunction

    function automatic logic [GRID_BITS-1:0] step_up(input logic [GRID_BITS-1:0] v);
        return (v == LAST) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [GRID_BITS-1:0] step_down(input logic [GRID_BITS-1:0] v);
        return (v == '0) ? LAST : v - 1'b1;
    endfunction

    assign mapper_display_addr = display_addr;
    assign offset_pos_x        = mapper_pixel_x;
    assign offset_pos_y        = mapper_pixel_y;
    assign px                  = mod_add(mapper_pixel_x, offset_y);
    assign py                  = mod_add(mapper_pixel_y, offset_x);
    assign pixel_addr          = {py, px};
    assign game_state          = state;

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) state <= ST_ARMED;
        else           state <= next_state;
    end

    always_comb begin
        next_state    = state;
        busy_next     = busy;
        cursor_x_next = cursor_x;
        cursor_y_next = cursor_y;
        wr_issue      = 1'b0;
        wr_pos_next   = ram_write_pos;
        wr_horiz_next = ram_write_horizontal;
        wr_inc_next   = ram_write_increase;
        rst_issue     = 1'b0;
        count_clear   = 1'b0;

        if (busy) begin
            if (instruction == 4'd0) busy_next = 1'b0;
        end else if (instruction != 4'd0) begin
            busy_next = 1'b1;
            if (instruction == 4'd6) begin
                rst_issue     = 1'b1;
                count_clear   = 1'b1;
                next_state    = ST_ARMED;
                cursor_x_next = '0;
                cursor_y_next = '0;
            end else if (state != ST_WIN) begin
                case (instruction)
                    4'd1: if (scramble) begin
                              wr_issue = 1'b1; wr_pos_next = cursor_x;
                              wr_horiz_next = 1'b0; wr_inc_next = 1'b1;
                          end else cursor_y_next = step_down(cursor_y);
                    4'd2: if (scramble) begin
                              wr_issue = 1'b1; wr_pos_next = cursor_y;
                              wr_horiz_next = 1'b1; wr_inc_next = 1'b0;
                          end else cursor_x_next = step_up(cursor_x);
                    4'd3: if (scramble) begin
                              wr_issue = 1'b1; wr_pos_next = cursor_y;
                              wr_horiz_next = 1'b1; wr_inc_next = 1'b1;
                          end else cursor_x_next = step_down(cursor_x);
                    4'd4: if (scramble) begin
                              wr_issue = 1'b1; wr_pos_next = cursor_x;
                              wr_horiz_next = 1'b0; wr_inc_next = 1'b0;
                          end else cursor_y_next = step_up(cursor_y);
                    4'd5: begin
                              rst_issue  = 1'b1;
                              next_state = ST_ARMED;
                          end
                    default: ;
                endcase
                if (wr_issue) next_state = ST_PLAY;
            end
        end

        // Win only when nothing else moved the state this edge; a fresh write keeps PLAY.
        if (state == ST_PLAY && next_state == ST_PLAY && !wr_issue &&
            settle == 2'd0 && offset_all_zero)
            next_state = ST_WIN;
    end

    assign in_window = (display_addr[21:11] >= X_MIN) && (display_addr[21:11] <= X_MAX) &&
                       (display_addr[10:0]  >= Y_MIN) && (display_addr[10:0]  <= Y_MAX);
    assign at_cursor = (mapper_pixel_x == cursor_x) && (mapper_pixel_y == cursor_y);

    always_comb begin
        pix_next = '0;
        if (in_window) begin
            if (phase && (state == ST_WIN || at_cursor)) pix_next = ~pixel_data;
            else                                         pix_next = pixel_data;
        end
    end

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            busy                 <= 1'b0;
            cursor_x             <= '0;
            cursor_y             <= '0;
            ram_write            <= 1'b0;
            ram_reset            <= 1'b0;
            ram_write_pos        <= '0;
            ram_write_horizontal <= 1'b0;
            ram_write_increase   <= 1'b0;
            settle               <= '0;
            move_count           <= '0;
            flash_cnt            <= '0;
            phase                <= 1'b0;
            display_data         <= '0;
        end else begin
            busy                 <= busy_next;
            cursor_x             <= cursor_x_next;
            cursor_y             <= cursor_y_next;
            ram_write            <= wr_issue;
            ram_reset            <= rst_issue;
            ram_write_pos        <= wr_pos_next;
            ram_write_horizontal <= wr_horiz_next;
            ram_write_increase   <= wr_inc_next;
            if (wr_issue)                settle <= 2'd2;
            else if (settle != 2'd0)     settle <= settle - 1'b1;
            if (count_clear)                      move_count <= '0;
            else if (wr_issue && move_count != '1) move_count <= move_count + 1'b1;
            flash_cnt <= flash_cnt + 1'b1;
            if (flash_cnt == '1) phase <= ~phase;
            display_data <= pix_next;
        end
    end

endmodule

// File: tb/tb_puzzle_gpu_core.sv
// Directed bench for puzzle_gpu_core (12x12 grid, 2-bit move counter, 3-bit flash counter);
// RAM writes are scoreboarded against expectations queued when each move is driven.
module tb_puzzle_gpu_core;

    logic        sysclk = 1'b0;
    logic        sysrst_n;
    logic [3:0]  instruction;
    logic        scramble, offset_all_zero;
    logic [21:0] display_addr;
    logic [3:0]  mapper_pixel_x, mapper_pixel_y, offset_x, offset_y;
    logic [2:0]  pixel_data;
    logic [21:0] mapper_display_addr;
    logic [3:0]  offset_pos_x, offset_pos_y;
    logic [7:0]  pixel_addr;
    logic [2:0]  display_data;
    logic        ram_write, ram_write_horizontal, ram_write_increase, ram_reset;
    logic [3:0]  ram_write_pos;
    logic [1:0]  move_count;
    logic [1:0]  game_state;

    puzzle_gpu_core #(
        .GRID_BITS (4),
        .GRID_SIZE (12),
        .FLASH_BITS(3),
        .MOVE_BITS (2)
    ) dut (
        .sysclk              (sysclk),
        .sysrst_n            (sysrst_n),
        .instruction         (instruction),
        .scramble            (scramble),
        .offset_all_zero     (offset_all_zero),
        .display_addr        (display_addr),
        .mapper_pixel_x      (mapper_pixel_x),
        .mapper_pixel_y      (mapper_pixel_y),
        .offset_x            (offset_x),
        .offset_y            (offset_y),
        .pixel_data          (pixel_data),
        .mapper_display_addr (mapper_display_addr),
        .offset_pos_x        (offset_pos_x),
        .offset_pos_y        (offset_pos_y),
        .pixel_addr          (pixel_addr),
        .display_data        (display_data),
        .ram_write           (ram_write),
        .ram_write_pos       (ram_write_pos),
        .ram_write_horizontal(ram_write_horizontal),
        .ram_write_increase  (ram_write_increase),
        .ram_reset           (ram_reset),
        .move_count          (move_count),
        .game_state          (game_state)
    );

    always #5 sysclk = ~sysclk;

    typedef struct packed {
        logic [3:0] pos;
        logic       h;
        logic       i;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  obs_wr[64];
    int   wr_seen = 0;
    int   rst_seen = 0;
    int   rd_idx = 0;
    int   exp_rst = 0;
    int   edge_n = 0;
    int   errors = 0;
    int   checks = 0;
    logic [1:0] exp_count;
    logic [2:0] exp_pix;

    always @(posedge sysclk) edge_n <= sysrst_n ? edge_n + 1 : 0;

    always @(negedge sysclk) begin
        if (ram_write && wr_seen < 64) begin
            obs_wr[wr_seen] = '{pos: ram_write_pos, h: ram_write_horizontal, i: ram_write_increase};
            wr_seen = wr_seen + 1;
        end
        if (ram_reset) rst_seen = rst_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic send(input logic [3:0] code);
        instruction = code;
        tick();
        instruction = 4'd0;
        tick();
    endtask

    task automatic expect_wr(input logic [3:0] pos, input logic h, input logic i);
        exp_q.push_back('{pos: pos, h: h, i: i});
        if (exp_count != 2'd3) exp_count = exp_count + 2'd1;
    endtask

    task automatic sb_drain();
        wr_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd_idx < wr_seen) begin
                check("wr_pos",  obs_wr[rd_idx].pos, e.pos);
                check("wr_horiz", obs_wr[rd_idx].h,  e.h);
                check("wr_inc",  obs_wr[rd_idx].i,   e.i);
                rd_idx++;
            end else begin
                check("wr_missing", wr_seen, rd_idx + 1);
            end
        end
        check("wr_extra", wr_seen, rd_idx);
    endtask

    // Phase used by the edge that just produced display_data.
    function automatic logic flash_phase();
        return 1'(((edge_n - 1) >> 3) & 1);
    endfunction

    task automatic pix_check(input string tag, input int n, input logic flashes);
        for (int k = 0; k < n; k++) begin
            tick();
            exp_pix = (flashes && flash_phase()) ? ~pixel_data : pixel_data;
            check(tag, display_data, exp_pix);
        end
    endtask

    initial begin
        sysrst_n = 1'b0; instruction = 4'd0; scramble = 1'b0; offset_all_zero = 1'b0;
        display_addr = '0; mapper_pixel_x = '0; mapper_pixel_y = '0;
        offset_x = '0; offset_y = '0; pixel_data = '0; exp_count = 2'd0;
        repeat (3) tick();
        check("rst_ram_write", ram_write, 1'b0);
        check("rst_ram_reset", ram_reset, 1'b0);
        check("rst_pos", ram_write_pos, 4'd0);
        check("rst_horiz", ram_write_horizontal, 1'b0);
        check("rst_inc", ram_write_increase, 1'b0);
        check("rst_display", display_data, 3'd0);
        check("rst_count", move_count, 2'd0);
        check("rst_state", game_state, 2'd0);

        // Combinational pass-through and modular pixel address.
        display_addr = 22'h2A_BCDE; mapper_pixel_x = 4'd7; mapper_pixel_y = 4'd11;
        offset_y = 4'd6; offset_x = 4'd11;
        #1;
        check("map_addr", mapper_display_addr, 22'h2A_BCDE);
        check("offpos_x", offset_pos_x, 4'd7);
        check("offpos_y", offset_pos_y, 4'd11);
        check("paddr_wrap", pixel_addr, {4'd10, 4'd1});
        mapper_pixel_x = 4'd3; offset_y = 4'd4; mapper_pixel_y = 4'd6; offset_x = 4'd6;
        #1;
        check("paddr_edge", pixel_addr, {4'd0, 4'd7});
        mapper_pixel_x = 4'd11; offset_y = 4'd0; mapper_pixel_y = 4'd0; offset_x = 4'd11;
        #1;
        check("paddr_max", pixel_addr, {4'd11, 4'd11});
        display_addr = '0; mapper_pixel_x = '0; mapper_pixel_y = '0; offset_x = '0; offset_y = '0;

        sysrst_n = 1'b1;
        tick();

        // First scramble move.
        scramble = 1'b1;
        send(4'd1); expect_wr(4'd0, 1'b0, 1'b1);
        check("first_count", move_count, exp_count);
        check("first_state", game_state, 2'd1);
        sb_drain();

        // Cursor wrap on a 12-wide grid, observed through later write positions.
        scramble = 1'b0;
        send(4'd3); send(4'd1);
        sb_drain();
        scramble = 1'b1;
        send(4'd1); expect_wr(4'd11, 1'b0, 1'b1);
        send(4'd3); expect_wr(4'd11, 1'b1, 1'b1);
        scramble = 1'b0;
        send(4'd2); send(4'd4);
        scramble = 1'b1;
        send(4'd2); expect_wr(4'd0, 1'b1, 1'b0);
        send(4'd4); expect_wr(4'd0, 1'b0, 1'b0);
        sb_drain();
        check("sat_count", move_count, 2'd3);

        // Held instruction executes once.
        instruction = 4'd2;
        repeat (50) tick();
        instruction = 4'd0;
        tick();
        expect_wr(4'd0, 1'b1, 1'b0);
        sb_drain();
        send(4'd2); expect_wr(4'd0, 1'b1, 1'b0);
        sb_drain();

        // Reset offsets keeps cursor and count; ARMED ignores offset_all_zero.
        scramble = 1'b0;
        send(4'd2);
        send(4'd5); exp_rst++;
        check("r5_pulses", rst_seen, exp_rst);
        check("r5_state", game_state, 2'd0);
        check("r5_count", move_count, 2'd3);
        offset_all_zero = 1'b1;
        repeat (6) tick();
        check("armed_nowin", game_state, 2'd0);
        offset_all_zero = 1'b0;
        scramble = 1'b1;
        send(4'd4); expect_wr(4'd1, 1'b0, 1'b0);
        sb_drain();
        repeat (2) tick();

        // Write coinciding with win condition, then settle delay before WIN.
        instruction = 4'd1; offset_all_zero = 1'b1;
        tick(); expect_wr(4'd1, 1'b0, 1'b1);
        check("simul_state", game_state, 2'd1);
        instruction = 4'd0;
        tick(); check("settle1_state", game_state, 2'd1);
        tick(); check("settle2_state", game_state, 2'd1);
        tick(); check("win_state", game_state, 2'd2);
        sb_drain();

        // WIN flashes every in-window tile.
        display_addr = {11'd231, 11'd100}; mapper_pixel_x = 4'd5; mapper_pixel_y = 4'd5;
        pixel_data = 3'b101;
        pix_check("win_flash", 16, 1'b1);

        send(4'd1);
        sb_drain();
        check("win_count", move_count, 2'd3);
        send(4'd5);
        check("win_r5_ignored", rst_seen, exp_rst);
        check("win_hold", game_state, 2'd2);
        offset_all_zero = 1'b0;
        send(4'd6); exp_rst++; exp_count = 2'd0;
        check("r6_pulses", rst_seen, exp_rst);
        check("r6_state", game_state, 2'd0);
        check("r6_count", move_count, 2'd0);
        send(4'd1); expect_wr(4'd0, 1'b0, 1'b1);
        sb_drain();
        check("r6_recount", move_count, exp_count);

        // Cursor flash, window edges.
        mapper_pixel_x = 4'd0; mapper_pixel_y = 4'd0;
        pix_check("cursor_flash", 16, 1'b1);
        display_addr = {11'd230, 11'd100};
        tick(); check("x_below", display_data, 3'd0);
        display_addr = {11'd231, 11'd100};
        mapper_pixel_x = 4'd1;
        pix_check("off_cursor", 8, 1'b0);
        display_addr = {11'd711, 11'd516};
        tick(); check("corner_in", display_data, 3'b101);
        display_addr = {11'd712, 11'd516};
        tick(); check("x_above", display_data, 3'd0);
        display_addr = {11'd231, 11'd35};
        tick(); check("y_below", display_data, 3'd0);
        display_addr = {11'd231, 11'd36};
        tick(); check("y_min", display_data, 3'b101);
        display_addr = {11'd231, 11'd517};
        tick(); check("y_above", display_data, 3'd0);

        sb_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
